// File: rtl/shaper_input_delay_line.sv
// ---------------------------------------------------------------------------
// shaper_input_delay_line
//
// Front end of the trapezoidal shaping chain. Each accepted ADC sample has
// the programmable baseline removed, is sign-extended to the tap width and
// pushed into a tapped delay line that the shaper reads for its k/l
// differences. A pulse-detection FSM produces the pulse_time window gate,
// the end_impuls strobe and the pileup/overflow window flags.
//
// Ports
//   clk                 system clock, all logic on posedge
//   reset_mult          asynchronous reset, active low
//   enable              channel enable; low forces the FSM idle, taps still shift
//   adc_data            unsigned ADC sample
//   adc_valid           sample qualifier
//   baseline            unsigned baseline subtracted from every sample
//   threshold           unsigned trigger level (against baseline-removed value)
//   k_trapezoidal       window constant k
//   l_trapezoidal       window constant l
//   hold_length         window constant hold
//   shift_reg_input_sig signed taps, [0] is the newest sample
//   pulse_time          pulse window gate
//   end_impuls          one-cycle end-of-pulse strobe
//   pileup              retrigger seen inside the current window
//   overflow            ADC saturation seen inside the current window
// ---------------------------------------------------------------------------
module shaper_input_delay_line #(
   parameter int SIZE_SHAPER_DATA         = 14,
   parameter int SIZE_SHAPER_ADD_CAPACITY = 9,
   parameter int SIZE_SHAPER_SHIFT_REG    = 60,
   parameter int SIZE_SHAPER_CONSTANT     = 8
) (
   input  logic                                   clk,
   input  logic                                   reset_mult,
   input  logic                                   enable,
   input  logic [SIZE_SHAPER_DATA-1:0]            adc_data,
   input  logic                                   adc_valid,
   input  logic [SIZE_SHAPER_DATA-1:0]            baseline,
   input  logic [SIZE_SHAPER_DATA-1:0]            threshold,
   input  logic [SIZE_SHAPER_CONSTANT-1:0]        k_trapezoidal,
   input  logic [SIZE_SHAPER_CONSTANT-1:0]        l_trapezoidal,
   input  logic [SIZE_SHAPER_CONSTANT-1:0]        hold_length,
   output logic [SIZE_SHAPER_SHIFT_REG-1:0]
                [SIZE_SHAPER_DATA+SIZE_SHAPER_ADD_CAPACITY:0] shift_reg_input_sig,
   output logic                                   pulse_time,
   output logic                                   end_impuls,
   output logic                                   pileup,
   output logic                                   overflow
);

   localparam int TW = SIZE_SHAPER_DATA + SIZE_SHAPER_ADD_CAPACITY + 1;
   localparam int CW = SIZE_SHAPER_CONSTANT + 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_END   = 2'd2,
      ST_DEAD  = 2'd3
   } state_t;

   state_t                 state, state_nxt;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic                   pileup_nxt;
   logic                   overflow_nxt;

   logic [SIZE_SHAPER_DATA:0] diff;
   logic [TW-1:0]             sample_ext;
   logic [TW-1:0]             threshold_ext;
   logic                      above;
   logic                      above1;
   logic                      adc_saturated;
   logic [CW-1:0]             window_sum;
   logic [CW-1:0]             window_load;

   // ------------------------------------------------------------------------
   // Baseline subtraction. Both operands are zero-extended by one bit so the
   // MSB of the difference is its sign; that bit is replicated up to TW.
   // ------------------------------------------------------------------------
   always_comb begin
      diff       = {1'b0, adc_data} - {1'b0, baseline};
      sample_ext = {{(TW-SIZE_SHAPER_DATA-1){diff[SIZE_SHAPER_DATA]}}, diff};
   end

   // ------------------------------------------------------------------------
   // Tapped delay line; shifts only on accepted samples, independent of
   // enable so the shaper history stays valid.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_mult) begin
      if (!reset_mult) begin
         shift_reg_input_sig <= '0;
      end else if (adc_valid) begin
         shift_reg_input_sig[0] <= sample_ext;
         for (int unsigned i = 1; i < SIZE_SHAPER_SHIFT_REG; i++) begin
            shift_reg_input_sig[i] <= shift_reg_input_sig[i-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Trigger qualifiers on the two newest taps, saturation detect on the raw
   // sample, and the window length (a zero-length window is forced to 1).
   // ------------------------------------------------------------------------
   always_comb begin
      threshold_ext = {{(TW-SIZE_SHAPER_DATA){1'b0}}, threshold};
      above         = $signed(shift_reg_input_sig[0]) > $signed(threshold_ext);
      above1        = $signed(shift_reg_input_sig[1]) > $signed(threshold_ext);
      adc_saturated = (adc_data == '1) || (adc_data == '0);
      window_sum    = {2'b00, k_trapezoidal} + {2'b00, l_trapezoidal}
                    + {2'b00, hold_length};
      window_load   = (window_sum == '0) ? CW'(1) : window_sum;
   end

   // ------------------------------------------------------------------------
   // Pulse FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_mult) begin
      if (!reset_mult) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         pileup   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         pileup   <= pileup_nxt;
         overflow <= overflow_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Pulse FSM: next state and flags. Everything except END->DEAD and the
   // enable override advances only on accepted samples.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pileup_nxt   = pileup;
      overflow_nxt = overflow;

      if (!enable) begin
         state_nxt    = ST_IDLE;
         pileup_nxt   = 1'b0;
         overflow_nxt = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // two consecutive samples above threshold debounce the trigger
               if (adc_valid && above && above1) begin
                  state_nxt    = ST_PULSE;
                  cnt_nxt      = window_load;
                  pileup_nxt   = 1'b0;
                  overflow_nxt = 1'b0;
               end
            end
            ST_PULSE: begin
               if (adc_valid) begin
                  if (adc_saturated) begin
                     overflow_nxt = 1'b1;
                  end
                  // fresh crossing inside the window restarts it (pile-up)
                  if (above && !above1) begin
                     cnt_nxt    = window_load;
                     pileup_nxt = 1'b1;
                  end else if (cnt == CW'(1)) begin
                     state_nxt = ST_END;
                  end else begin
                     cnt_nxt = cnt - CW'(1);
                  end
               end
            end
            ST_END: begin
               state_nxt = ST_DEAD;
               if (adc_valid && adc_saturated) begin
                  overflow_nxt = 1'b1;
               end
            end
            ST_DEAD: begin
               // hold off until the pulse tail has dropped below threshold
               if (adc_valid && !above) begin
                  state_nxt = ST_IDLE;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      pulse_time = (state == ST_PULSE);
      end_impuls = (state == ST_END);
   end

endmodule

// File: tb/tb_shaper_input_delay_line.sv
module tb_shaper_input_delay_line;

   logic                 clk = 1'b0;
   logic                 reset_mult;
   logic                 enable;
   logic [13:0]          adc_data;
   logic                 adc_valid;
   logic [13:0]          baseline;
   logic [13:0]          threshold;
   logic [7:0]           k_trapezoidal;
   logic [7:0]           l_trapezoidal;
   logic [7:0]           hold_length;
   logic [59:0][23:0]    taps;
   logic                 pulse_time;
   logic                 end_impuls;
   logic                 pileup;
   logic                 overflow;

   int n_tests = 0;
   int n_fail  = 0;

   // scoreboard of expected pulse_time lengths (in clocks), popped on end_impuls
   int exp_len_q[$];
   int run_len;
   int acc_in_pulse;
   int end_cnt;
   logic [23:0] mtap [60];

   shaper_input_delay_line #(
      .SIZE_SHAPER_DATA(14),
      .SIZE_SHAPER_ADD_CAPACITY(9),
      .SIZE_SHAPER_SHIFT_REG(60),
      .SIZE_SHAPER_CONSTANT(8)
   ) dut (
      .clk(clk),
      .reset_mult(reset_mult),
      .enable(enable),
      .adc_data(adc_data),
      .adc_valid(adc_valid),
      .baseline(baseline),
      .threshold(threshold),
      .k_trapezoidal(k_trapezoidal),
      .l_trapezoidal(l_trapezoidal),
      .hold_length(hold_length),
      .shift_reg_input_sig(taps),
      .pulse_time(pulse_time),
      .end_impuls(end_impuls),
      .pileup(pileup),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 60; i++) mtap[i] = '0;
   endtask

   task automatic check_taps(input string tag);
      int idx;
      bit found;
      idx = 0;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (!found && taps[i] !== mtap[i]) begin
            idx = i;
            found = 1'b1;
         end
      end
      chk(tag, taps[idx], mtap[idx]);
   endtask

   task automatic step(input logic [13:0] a, input logic v);
      int exp_len;
      adc_data  = a;
      adc_valid = v;
      @(posedge clk);
      #1;
      if (v) begin
         for (int i = 59; i > 0; i--) mtap[i] = mtap[i-1];
         mtap[0] = 24'(int'(a) - int'(baseline));
      end
      if (pulse_time) begin
         run_len++;
         if (v) acc_in_pulse++;
      end
      if (end_impuls) begin
         end_cnt++;
         chk("sb_pending", exp_len_q.size() > 0, 1);
         if (exp_len_q.size() > 0) begin
            exp_len = exp_len_q.pop_front();
            chk("window_len", run_len, exp_len);
         end
         run_len = 0;
      end
   endtask

   initial begin
      reset_mult    = 1'b0;
      enable        = 1'b1;
      adc_data      = 14'd500;
      adc_valid     = 1'b1;
      baseline      = 14'd100;
      threshold     = 14'd16000;
      k_trapezoidal = 8'd10;
      l_trapezoidal = 8'd5;
      hold_length   = 8'd8;
      run_len       = 0;
      acc_in_pulse  = 0;
      end_cnt       = 0;
      clear_model();

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_taps("reset_taps");
      chk("reset_tap0", taps[0], 0);
      chk("reset_pulse_time", pulse_time, 0);
      chk("reset_end_impuls", end_impuls, 0);
      chk("reset_pileup", pileup, 0);
      chk("reset_overflow", overflow, 0);
      @(negedge clk);
      reset_mult = 1'b1;

      // fill the line: 500 - 100 everywhere
      repeat (60) step(14'd500, 1'b1);
      chk("fill_tap0", taps[0], 24'd400);
      chk("fill_tap59", taps[59], 24'd400);
      check_taps("fill_all");

      // sign extension and propagation to the last tap
      step(14'd0, 1'b1);
      chk("sign_tap0", taps[0], 24'hFFFF9C);
      repeat (59) step(14'd500, 1'b1);
      chk("sign_tap59", taps[59], 24'hFFFF9C);
      chk("sign_tap58", taps[58], 24'd400);
      check_taps("sign_all");
      chk("no_pulse_high_thr", pulse_time, 0);

      // flush trigger taps before lowering the threshold
      repeat (3) step(14'd100, 1'b1);
      threshold = 14'd50;

      // basic pulse, continuous valid, W = 10+5+8 = 23
      run_len = 0; end_cnt = 0;
      exp_len_q.push_back(23);
      for (int i = 1; i <= 40; i++) begin
         step(14'd300, 1'b1);
         if (i == 2)  chk("pulse_not_yet", pulse_time, 0);
         if (i == 3)  chk("pulse_start", pulse_time, 1);
         if (i == 25) chk("pulse_last", pulse_time, 1);
         if (i == 26) begin
            chk("end_strobe", end_impuls, 1);
            chk("end_pulse_low", pulse_time, 0);
         end
         if (i == 27) chk("end_one_clk", end_impuls, 0);
      end
      chk("pulse_end_count", end_cnt, 1);
      chk("dead_no_retrigger", run_len, 0);
      repeat (3) step(14'd100, 1'b1);
      chk("idle_pulse", pulse_time, 0);
      chk("idle_pileup", pileup, 0);
      chk("idle_overflow", overflow, 0);

      // single-sample spike must not trigger
      run_len = 0;
      step(14'd300, 1'b1);
      repeat (5) step(14'd100, 1'b1);
      chk("spike_no_pulse", run_len, 0);

      // alternating valid: 23 accepted samples spanning 46 clocks
      run_len = 0; acc_in_pulse = 0; end_cnt = 0;
      exp_len_q.push_back(46);
      repeat (35) begin
         step(14'd300, 1'b1);
         step(14'd300, 1'b0);
      end
      chk("alt_end_count", end_cnt, 1);
      chk("alt_accepted", acc_in_pulse, 23);
      repeat (3) step(14'd100, 1'b1);

      // pile-up reload at sample 13, overflow sample at 20: 3 + 10 + 23 - 3 = 33
      run_len = 0; end_cnt = 0;
      exp_len_q.push_back(33);
      for (int i = 1; i <= 45; i++) begin
         step((i == 11) ? 14'd100 : (i == 20) ? 14'd16383 : 14'd300, 1'b1);
         if (i == 12) chk("pileup_before", pileup, 0);
         if (i == 13) chk("pileup_set", pileup, 1);
         if (i == 19) chk("overflow_before", overflow, 0);
         if (i == 20) chk("overflow_set", overflow, 1);
         if (i == 35) chk("pileup_pulse_last", pulse_time, 1);
         if (i == 36) chk("pileup_end", end_impuls, 1);
      end
      chk("pileup_end_count", end_cnt, 1);
      chk("pileup_held_dead", pileup, 1);
      chk("overflow_held_dead", overflow, 1);
      repeat (3) step(14'd100, 1'b1);
      chk("pileup_held_idle", pileup, 1);
      chk("overflow_held_idle", overflow, 1);

      // enable dropped inside the window
      run_len = 0; end_cnt = 0;
      for (int i = 1; i <= 11; i++) begin
         step((i == 8) ? 14'd16383 : 14'd300, 1'b1);
         if (i == 3) begin
            chk("entry_clears_pileup", pileup, 0);
            chk("entry_clears_overflow", overflow, 0);
         end
         if (i == 8) chk("en_overflow_set", overflow, 1);
      end
      chk("en_pulse_before", pulse_time, 1);
      enable = 1'b0;
      step(14'd350, 1'b1);
      chk("en_pulse_drop", pulse_time, 0);
      chk("en_no_end", end_impuls, 0);
      chk("en_overflow_clr", overflow, 0);
      chk("en_tap0_shift", taps[0], 24'd250);
      repeat (3) step(14'd100, 1'b1);
      chk("en_end_count", end_cnt, 0);
      check_taps("en_taps_shift");
      enable = 1'b1;
      step(14'd100, 1'b1);
      chk("en_back_idle", pulse_time, 0);
      chk("sb_drained", exp_len_q.size(), 0);

      // asynchronous reset mid-pulse
      run_len = 0; end_cnt = 0;
      repeat (8) step(14'd300, 1'b1);
      chk("rst_pulse_before", pulse_time, 1);
      #2 reset_mult = 1'b0;
      #1;
      chk("rst_async_pulse", pulse_time, 0);
      chk("rst_async_tap0", taps[0], 0);
      chk("rst_async_end", end_impuls, 0);
      clear_model();
      @(negedge clk);
      reset_mult = 1'b1;
      repeat (3) step(14'd100, 1'b1);
      chk("rst_no_end", end_cnt, 0);
      check_taps("rst_taps");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
